// File: rtl/reg_array_reader.sv
// Snapshots an N-word parallel bus on start, then streams one word per out_valid&&out_ready (natural or bit-reversed order).
// First word valid one cycle after the start edge; outputs hold while out_ready is low; a done pulse follows the last transfer.
module reg_array_reader #(
    parameter int N      = 16,
    parameter int MSB    = 16,
    parameter int BITREV = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N*MSB-1:0]       data_in,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [MSB-1:0]         out_data,
    output logic [$clog2(N)-1:0]   out_addr,
    output logic                   busy,
    output logic                   done
);
    localparam int AW = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [AW-1:0]  count_q, count_d;
    logic [MSB-1:0] out_data_q, out_data_d;
    logic [AW-1:0]  out_addr_q, out_addr_d;
    logic [MSB-1:0] snap_q [N];
    logic           load;
    logic [AW-1:0]  next_addr;

    function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] c);
        logic [AW-1:0] r;
        r = c;
        if (BITREV != 0) begin
            for (int i = 0; i < AW; i++) begin
                r[i] = c[AW-1-i];
            end
        end
        return r;
    endfunction

    // The next word is looked up one cycle early so out_data stays a plain register.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        out_data_d = out_data_q;
        out_addr_d = out_addr_q;
        load       = 1'b0;
        next_addr  = map_addr(count_q + 1'b1);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_d    = S_SEND;
                    count_d    = '0;
                    out_addr_d = '0;
                    out_data_d = data_in[MSB-1:0];
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    count_d = count_q + 1'b1;
                    if (count_q == AW'(N - 1)) begin
                        state_d    = S_DONE;
                        out_addr_d = '0;
                        out_data_d = '0;
                    end else begin
                        out_addr_d = next_addr;
                        out_data_d = snap_q[next_addr];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            out_data_q <= '0;
            out_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
            out_addr_q <= out_addr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                snap_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < N; i++) begin
                snap_q[i] <= data_in[i*MSB +: MSB];
            end
        end
    end

    assign out_valid = (state_q == S_SEND);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_reg_array_reader.sv
// Bench for reg_array_reader: a natural-order N=16 instance and a bit-reversed N=8 instance against a behavioural model.
module tb_reg_array_reader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         start0, rdy0, vld0, busy0, done0;
    logic [255:0] din0;
    logic [15:0]  dat0;
    logic [3:0]   adr0;

    logic         start1, rdy1, vld1, busy1, done1;
    logic [127:0] din1;
    logic [15:0]  dat1;
    logic [2:0]   adr1;

    reg_array_reader #(.N(16), .MSB(16), .BITREV(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .data_in(din0), .out_ready(rdy0),
        .out_valid(vld0), .out_data(dat0), .out_addr(adr0), .busy(busy0), .done(done0)
    );

    reg_array_reader #(.N(8), .MSB(16), .BITREV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .data_in(din1), .out_ready(rdy1),
        .out_valid(vld1), .out_data(dat1), .out_addr(adr1), .busy(busy1), .done(done1)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] word0 [16], alt0 [16], altb0 [16], exp0 [16], expb0 [16];
    logic [15:0] word1 [8],  alt1 [8],  altb1 [8],  exp1 [8];

    int q_dat[$], q_adr[$], q_xcyc[$], q_done[$];
    int stable_err, both_err;
    bit timeout;

    // Reference order: k-th word emitted comes from index k, or k with its log2(n) bits mirrored.
    function automatic int model_idx(input int k, input int n, input bit rev);
        int r, x, m;
        if (!rev) return k;
        r = 0; x = k; m = n;
        while (m > 1) begin
            r = r * 2 + (x % 2);
            x = x / 2;
            m = m / 2;
        end
        return r;
    endfunction

    task automatic drive_bus();
        for (int i = 0; i < 16; i++) din0[i*16 +: 16] = word0[i];
        for (int i = 0; i < 8; i++)  din1[i*16 +: 16] = word1[i];
    endtask

    // Caller raises start at a negedge (cycle 0); cycle c is the c-th cycle after the accept edge.
    task automatic collect(input int which, input bit rand_rdy, input bit keep_start, input int n_bursts,
                           input int chg_cyc, input int chg2_cyc, input int restart_cyc, input int max_cyc);
        int c, ndone, h_dat, h_adr, d, a;
        bit held, v, dn, r;
        q_dat.delete(); q_adr.delete(); q_xcyc.delete(); q_done.delete();
        timeout = 0; stable_err = 0; both_err = 0; held = 0; ndone = 0; h_dat = 0; h_adr = 0;
        for (c = 1; c <= max_cyc && ndone < n_bursts; c++) begin
            @(negedge clk);
            v  = (which == 0) ? vld0 : vld1;
            dn = (which == 0) ? done0 : done1;
            d  = (which == 0) ? int'(dat0) : int'(dat1);
            a  = (which == 0) ? int'(adr0) : int'(adr1);
            if (v && dn) both_err++;
            if (held && (!v || d != h_dat || a != h_adr)) stable_err++;
            if (dn) begin
                q_done.push_back(c);
                ndone++;
            end
            if (!keep_start) begin
                if (which == 0) start0 = (c == restart_cyc); else start1 = (c == restart_cyc);
            end
            if (c == chg_cyc)  begin word0 = alt0;  word1 = alt1;  drive_bus(); end
            if (c == chg2_cyc) begin word0 = altb0; word1 = altb1; drive_bus(); end
            r = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (which == 0) rdy0 = r; else rdy1 = r;
            if (v && r) begin
                q_dat.push_back(d); q_adr.push_back(a); q_xcyc.push_back(c);
                held = 0;
            end else if (v) begin
                held = 1; h_dat = d; h_adr = a;
            end else begin
                held = 0;
            end
        end
        if (ndone < n_bursts) timeout = 1;
        start0 = 1'b0; start1 = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start0 = 0; start1 = 0; rdy0 = 1; rdy1 = 1;
        for (int i = 0; i < 16; i++) word0[i] = 16'hA000 + 16'(i);
        for (int i = 0; i < 8; i++)  word1[i] = 16'h0;
        drive_bus();
        #12;
        checks++;
        if ({vld0, busy0, done0, dat0, adr0, vld1, busy1, done1, dat1, adr1} !== '0) begin
            failures++;
            $display("FAIL reset_state: got v/b/d=%b%b%b data=%h addr=%0d, want all zero", vld0, busy0, done0, dat0, adr0);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); start0 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start0 = 1'b0;
        end
        checks++;
        if (!(vld0 === 1'b1 && adr0 === 4'd3 && dat0 === 16'hA003)) begin
            failures++;
            $display("FAIL reset_pre_word: got v=%b addr=%0d data=%h, want v=1 addr=3 data=a003", vld0, adr0, dat0);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({vld0, busy0, done0, dat0, adr0} !== '0) begin
            failures++;
            $display("FAIL reset_midburst: got v/b/d=%b%b%b data=%h addr=%0d, want all zero", vld0, busy0, done0, dat0, adr0);
        end
        @(negedge clk); rst = 1'b0;
        begin
            int bad;
            bad = 0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                if (vld0 || done0 || busy0) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL reset_quiet: got %0d active cycles after reset, want 0", bad);
            end
        end
        start0 = 1'b1;
        collect(0, 0, 0, 1, -1, -1, -1, 60);
        checks++;
        if (timeout || q_adr.size() != 16 || q_adr[0] != 0 || q_dat[0] != 32'hA000) begin
            failures++;
            $display("FAIL reset_restart: got words=%0d first addr=%0d timeout=%0d, want 16 words from addr 0",
                     q_adr.size(), (q_adr.size() > 0) ? q_adr[0] : -1, timeout);
        end
    endtask

    task automatic test_natural();
        for (int i = 0; i < 16; i++) word0[i] = 16'hA000 + 16'(i);
        drive_bus();
        exp0 = word0;
        @(negedge clk); start0 = 1'b1;
        collect(0, 0, 0, 1, -1, -1, -1, 60);
        checks++;
        if (timeout || q_done.size() != 1 || q_done[0] != 17 || both_err != 0) begin
            failures++;
            $display("FAIL nat_done: got done cycles=%p overlap=%0d timeout=%0d, want done only at 17", q_done, both_err, timeout);
        end
        for (int k = 0; k < 16; k++) begin
            int gd, ga, gc, ei;
            ei = model_idx(k, 16, 0);
            gd = (k < q_dat.size()) ? q_dat[k] : -1;
            ga = (k < q_adr.size()) ? q_adr[k] : -1;
            gc = (k < q_xcyc.size()) ? q_xcyc[k] : -1;
            checks++;
            if (gd != int'(exp0[ei]) || ga != ei || gc != k + 1) begin
                failures++;
                $display("FAIL nat_word%0d: got data=%h addr=%0d cyc=%0d, want data=%h addr=%0d cyc=%0d",
                         k, gd, ga, gc, exp0[ei], ei, k + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int nok;
        for (int i = 0; i < 16; i++) word0[i] = 16'hA000 + 16'(i);
        drive_bus();
        exp0 = word0;
        @(negedge clk); start0 = 1'b1;
        collect(0, 1, 0, 1, -1, -1, -1, 400);
        checks++;
        if (timeout || q_dat.size() != 16 || stable_err != 0 || both_err != 0 || q_done.size() != 1) begin
            failures++;
            $display("FAIL bp_flow: got words=%0d unstable=%0d overlap=%0d dones=%0d timeout=%0d, want 16/0/0/1/0",
                     q_dat.size(), stable_err, both_err, q_done.size(), timeout);
        end else begin
            checks++;
            if (q_done[0] != q_xcyc[15] + 1) begin
                failures++;
                $display("FAIL bp_done_cyc: got %0d, want %0d", q_done[0], q_xcyc[15] + 1);
            end
        end
        nok = 0;
        for (int k = 0; k < 16 && k < q_dat.size(); k++)
            if (q_dat[k] == int'(exp0[k]) && q_adr[k] == k) nok++;
        checks++;
        if (nok != 16) begin
            failures++;
            $display("FAIL bp_order: got %0d in-order words, want 16", nok);
        end
    endtask

    task automatic run_dut1_burst(input bit rand_rdy, input string tag);
        exp1 = word1;
        @(negedge clk); start1 = 1'b1;
        collect(1, rand_rdy, 0, 1, -1, -1, -1, 300);
        checks++;
        if (timeout || q_dat.size() != 8 || stable_err != 0 || both_err != 0 || q_done.size() != 1) begin
            failures++;
            $display("FAIL %s_flow: got words=%0d unstable=%0d overlap=%0d dones=%0d timeout=%0d, want 8/0/0/1/0",
                     tag, q_dat.size(), stable_err, both_err, q_done.size(), timeout);
        end
        for (int k = 0; k < 8; k++) begin
            int gd, ga, ei;
            ei = model_idx(k, 8, 1);
            gd = (k < q_dat.size()) ? q_dat[k] : -1;
            ga = (k < q_adr.size()) ? q_adr[k] : -1;
            checks++;
            if (gd != int'(exp1[ei]) || ga != ei) begin
                failures++;
                $display("FAIL %s_word%0d: got data=%h addr=%0d, want data=%h addr=%0d", tag, k, gd, ga, exp1[ei], ei);
            end
        end
    endtask

    task automatic test_bitrev();
        for (int i = 0; i < 8; i++) word1[i] = 16'(i * 3);
        drive_bus();
        run_dut1_burst(0, "brev");
        checks++;
        if (q_done.size() != 1 || q_done[0] != 9) begin
            failures++;
            $display("FAIL brev_done_cyc: got %p, want 9", q_done);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) word1[i] = 16'($urandom);
        drive_bus();
        run_dut1_burst(1, "rnd");
    endtask

    task automatic test_snapshot();
        int bad;
        for (int i = 0; i < 16; i++) begin
            word0[i] = 16'hA000 + 16'(i);
            alt0[i]  = 16'hFFFF;
        end
        for (int i = 0; i < 8; i++) alt1[i] = word1[i];
        drive_bus();
        exp0 = word0;
        @(negedge clk); start0 = 1'b1;
        collect(0, 0, 0, 1, 1, -1, 5, 60);
        checks++;
        if (timeout || q_dat.size() != 16 || q_done.size() != 1 || q_done[0] != 17) begin
            failures++;
            $display("FAIL snap_flow: got words=%0d done=%p timeout=%0d, want 16 words, done at 17", q_dat.size(), q_done, timeout);
        end
        bad = 0;
        for (int k = 0; k < 16 && k < q_dat.size(); k++)
            if (q_dat[k] != int'(exp0[k])) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL snap_data: got %0d words differing from snapshot, want 0", bad);
        end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (vld0 || done0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL snap_second_start: got %0d active cycles after done, want 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            word0[i] = 16'($urandom);
            alt0[i]  = 16'($urandom);
            altb0[i] = 16'($urandom);
        end
        for (int i = 0; i < 8; i++) begin
            alt1[i] = word1[i]; altb1[i] = word1[i];
        end
        drive_bus();
        exp0 = word0; expb0 = alt0;
        @(negedge clk); start0 = 1'b1;
        collect(0, 0, 1, 2, 3, 19, -1, 80);
        checks++;
        if (timeout || q_done.size() != 2 || q_done[0] != 17 || q_done[1] != 35) begin
            failures++;
            $display("FAIL b2b_done: got %p timeout=%0d, want done at 17 and 35", q_done, timeout);
        end
        checks++;
        if (q_xcyc.size() != 32 || q_xcyc[0] != 1 || q_xcyc[16] != 19) begin
            failures++;
            $display("FAIL b2b_start_cyc: got %0d words, burst starts %0d/%0d, want 32 words at 1/19",
                     q_xcyc.size(), (q_xcyc.size() > 0) ? q_xcyc[0] : -1, (q_xcyc.size() > 16) ? q_xcyc[16] : -1);
        end
        for (int b = 0; b < 2; b++) begin
            int bad;
            bad = 0;
            for (int k = 0; k < 16; k++) begin
                int j, e;
                j = b * 16 + k;
                e = (b == 0) ? int'(exp0[k]) : int'(expb0[k]);
                if (j >= q_dat.size() || q_dat[j] != e || q_adr[j] != k) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL b2b_burst%0d: got %0d wrong words, want 0", b, bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_natural();
        test_backpressure();
        test_bitrev();
        test_random();
        test_snapshot();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_array_reader.md
# reg_array_reader

Parallel-to-serial reader for FFT stage result banks. On a start pulse it snapshots an N-word parallel bus (word i at bits [(i+1)*MSB-1 : i*MSB]), then streams the words out one per accepted handshake, in natural or bit-reversed index order. It sits after an FFT stage's register array and feeds the serial output path (UART/SPI formatter) of the design.

## Interface
- N, 16, number of words; power of two, ≥2
- MSB, 16, word width in bits
- BITREV, 0, 1 = emit words in bit-reversed index order; 0 = natural order 0..N-1

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request to snapshot data_in and begin a burst; honoured only in IDLE
- data_in  in  N*MSB  parallel word bus, word i at [(i+1)*MSB-1 : i*MSB]
- out_ready  in  1  downstream accepts out_data this cycle
- out_valid  out  1  out_data/out_addr hold a valid word
- out_data  out  MSB  current word
- out_addr  out  $clog2(N)  source index i of out_data within data_in
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last word is accepted

## Operation
- States: IDLE, SEND, DONE.
- IDLE: out_valid=0, busy=0. start=1 at a rising edge → copy all N words of data_in into an internal snapshot, clear count, go SEND.
- SEND: out_valid=1, busy=1. out_addr = count (BITREV=0) or bit-reverse of count over $clog2(N) bits (BITREV=1); out_data = snapshot[out_addr].
- Transfer occurs at a rising edge where out_valid && out_ready. On transfer: count+1; if count was N-1 → DONE.
- No transfer (out_ready=0): out_valid, out_data, out_addr held stable; no word skipped or repeated.
- DONE: out_valid=0, busy=1→ drops; done=1 for exactly this cycle; next edge → IDLE unconditionally.
- start is ignored in SEND and DONE; data_in changes after the snapshot edge have no effect on the burst.
- count is $clog2(N) bits and wraps only via the SEND→DONE transition; never emits more than N words per burst.
- out_data and out_addr are registered outputs (no combinational path from data_in or out_ready to them).
- out_valid does not depend combinationally on out_ready.

## Timing
- Reset (async assert, any state): state=IDLE, count=0, snapshot cleared to 0, out_valid=0, out_data=0, out_addr=0, busy=0, done=0. Reset mid-burst aborts with no done pulse.
- Latency: start sampled at edge T → out_valid=1 with first word from edge T+1.
- With out_ready held 1: one word per cycle, words at T+1..T+N, done high in cycle T+N+1, IDLE from T+N+2; earliest next start accepted at edge T+N+2.
- Throughput back-to-back: N words per N+2 cycles.
- start held high continuously: a new burst begins every N+2 cycles, each snapshotting data_in at its own accept edge.
- done and out_valid never high in the same cycle.

## Test plan
- Reset: assert rst mid-SEND (after 3 words, N=16) → out_valid, busy, done, out_data, out_addr all 0 immediately; no done pulse; next start restarts at word 0.
- Natural order, out_ready=1, N=16, MSB=16, data_in word i = 16'hA000+i: start at edge T → out_data A000..A00F, out_addr 0..15 on cycles T+1..T+16, done=1 at T+17 only.
- Backpressure: same data, out_ready toggled 1,0,0,1,... random → exactly 16 transfers, values A000..A00F in order, out_data/out_addr stable on every ready=0 cycle.
- BITREV=1, N=8, word i = i*3: sequence out_addr 0,4,2,6,1,5,3,7 with out_data 0,12,6,18,3,15,9,21.
- Snapshot isolation: change data_in to all-FFFF one cycle after start; start pulse again during SEND → burst still outputs original values, second start ignored, exactly one done.
- Continuous start=1, out_ready=1, data_in changed between bursts → two complete bursts 18 cycles apart, each reflecting data_in at its accept edge.
